generador_estado: RTL and testbench

Sequential source of the `estado`/`avance`/`credito` signal set consumed by the stage-code mapper. Accumulates coin credit, charges `PRICE` on a valid start, then steps a 3-bit stage index through 0..5, one stage per `CYCLES_PER_STAGE` clocks. Emits a one-cycle `avance` pulse at the end of each stage while holding `credito` high for the whole paid run. Sits between the user inputs (coin, start, cancel) and the combinational stage decoder.

---
 rtl/generador_estado.sv | 59 +++++
 tb/tb_generador_estado.sv | 95 +++++++++
 2 files changed

// File: rtl/generador_estado.sv
// generador_estado: coin-credited stage sequencer driving estado/avance/credito for the stage decoder.
module generador_estado #(
  parameter int CYCLES_PER_STAGE = 8,
  parameter int PRICE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin,
  input  logic       start,
  input  logic       cancel,
  output logic [2:0] estado,
  output logic       avance,
  output logic       credito,
  output logic [3:0] credit_count,
  output logic       credit_ok,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_timer;
  logic [2:0]  r_estado;
  logic [3:0]  r_credit, w_credit;
  logic        w_last, w_go, w_final;
  assign w_last  = r_timer == 16'(CYCLES_PER_STAGE - 1);
  assign w_final = w_last && r_estado == 3'd5;
  assign credit_ok = r_credit >= 4'(PRICE);
  assign w_go = r_state == IDLE && start && credit_ok;
  // cancel wins over the end-of-stage pulse in the same cycle
  assign avance = r_state == RUN && w_last && !cancel;
  assign w_credit = w_go ? r_credit - 4'(PRICE) + {3'd0, coin}
                  : (coin && r_credit != 4'd15) ? r_credit + 4'd1 : r_credit;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? RUN : IDLE;
      RUN:     w_next = cancel ? IDLE : w_final ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_estado <= '0;
      r_credit <= '0;
    end else begin
      r_state  <= w_next;
      r_credit <= w_credit;
      r_timer  <= (r_state != RUN || cancel || w_last) ? 16'd0 : r_timer + 16'd1;
      r_estado <= (r_state != RUN || cancel || w_final) ? 3'd0 : w_last ? r_estado + 3'd1 : r_estado;
    end
  end
  assign estado       = r_estado;
  assign credit_count = r_credit;
  assign busy         = r_state == RUN;
  assign credito      = r_state == RUN;
  assign done         = r_state == DONE;
endmodule

// File: tb/tb_generador_estado.sv
// tb_generador_estado: directed checks of credit, run timing, cancel and ignored starts with N=4, PRICE=3.
module tb_generador_estado;
  logic       clk = 0, rst = 1, coin = 0, start = 0, cancel = 0;
  logic [2:0] estado;
  logic       avance, credito, credit_ok, busy, done;
  logic [3:0] credit_count;
  int         n_checks = 0, n_fail = 0;
  generador_estado #(.CYCLES_PER_STAGE(4), .PRICE(3)) dut (
    .clk(clk), .rst(rst), .coin(coin), .start(start), .cancel(cancel),
    .estado(estado), .avance(avance), .credito(credito), .credit_count(credit_count),
    .credit_ok(credit_ok), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] outs();
    return {20'd0, estado, avance, credito, credit_count, credit_ok, busy, done};
  endfunction
  initial begin
    logic [3:0] exp_c;
    logic       saw_done;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      chk("reset_outs", outs(), 0);
      step();
    end
    coin = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_c = (i > 15) ? 4'd15 : 4'(i);
      chk("credit_sat", {credit_ok, credit_count}, {exp_c >= 4'd3, exp_c});
    end
    coin = 0;
    rst = 1; step(); rst = 0;
    chk("credit_cleared", credit_count, 0);
    coin = 1; repeat (3) step(); coin = 0;
    chk("credit_three", {credit_ok, credit_count}, {1'b1, 4'd3});
    start = 1; step(); start = 0;
    chk("charged", credit_count, 0);
    for (int o = 1; o <= 26; o++) begin
      logic       b, a, d;
      logic [2:0] e;
      b = o <= 24;
      a = b && (o % 4 == 0);
      d = o == 25;
      e = b ? 3'((o - 1) / 4) : 3'd0;
      chk($sformatf("run_o%0d", o), {busy, credito, avance, done, estado}, {b, b, a, d, e});
      step();
    end
    coin = 1; repeat (2) step(); coin = 0;
    start = 1; step(); start = 0;
    chk("poor_start", {busy, credit_count}, {1'b0, 4'd2});
    coin = 1; start = 1; step(); coin = 0; start = 0;
    chk("coin_start_same", {busy, credit_count}, {1'b0, 4'd3});
    start = 1; step(); start = 0;
    repeat (7) step();
    cancel = 1; #1;
    chk("cancel_avance", {busy, avance, estado}, {1'b1, 1'b0, 3'd1});
    step(); cancel = 0;
    chk("cancel_idle", {busy, credito, estado, credit_count}, {1'b0, 1'b0, 3'd0, 4'd0});
    saw_done = 0;
    for (int i = 0; i < 30; i++) begin
      saw_done |= done;
      step();
    end
    chk("cancel_no_done", saw_done, 0);
    coin = 1; repeat (5) step();
    start = 1; step(); coin = 0; start = 0;
    chk("start_with_coin", {busy, credit_count}, {1'b1, 4'd3});
    start = 1; step(); start = 0;
    chk("ignored_start", {busy, estado, credit_count}, {1'b1, 3'd0, 4'd3});
    repeat (2) step();
    chk("timer_intact", {avance, estado}, {1'b1, 3'd0});
    rst = 1; step(); rst = 0;
    chk("rst_in_run", outs(), 0);
    saw_done = 0;
    for (int i = 0; i < 30; i++) begin
      saw_done |= done | busy;
      step();
    end
    chk("rst_no_done", saw_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
